free_list_mw: RTL

- Multi-width physical-register free list for the rename stage: up to ALLOC_WIDTH allocations and COMMIT_WIDTH frees per cycle.
- Circular FIFO of free preg IDs with per-checkpoint head snapshots for branch-mispredict recovery.
- Full-flush recovery for exceptions.
- Sits between rename (allocate, checkpoint) and ROB commit (free old preg).

---
 rtl/free_list_mw.sv | 111 +++++++++++
 1 files changed

// File: rtl/free_list_mw.sv
// rtl/free_list_mw.sv - multi-width physical register free list with checkpointed head recovery
module free_list_mw #(
    parameter int PREG_WIDTH   = 7,
    parameter int NUM_AREGS    = 32,
    parameter int ALLOC_WIDTH  = 2,
    parameter int COMMIT_WIDTH = 2,
    parameter int CKPT_WIDTH   = 4
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [ALLOC_WIDTH-1:0]              alloc_req,
    output logic                                alloc_gnt,
    output logic [ALLOC_WIDTH*PREG_WIDTH-1:0]   alloc_preg,
    output logic [PREG_WIDTH:0]                 free_count,
    input  logic [COMMIT_WIDTH-1:0]             commit_en,
    input  logic [COMMIT_WIDTH*PREG_WIDTH-1:0]  commit_old_preg,
    input  logic                                ckpt_save,
    input  logic [CKPT_WIDTH-1:0]               ckpt_tag,
    input  logic                                restore,
    input  logic [CKPT_WIDTH-1:0]               restore_tag,
    input  logic                                flush,
    output logic                                overflow_err
);

    localparam int NUM_PREGS = 1 << PREG_WIDTH;
    localparam int FREE_N    = NUM_PREGS - NUM_AREGS;
    localparam int NUM_CKPT  = 1 << CKPT_WIDTH;

    typedef logic [PREG_WIDTH:0] ptr_t;

    localparam ptr_t FREE_N_P = ptr_t'(FREE_N);

    logic [PREG_WIDTH-1:0] queue [NUM_PREGS];
    ptr_t                  snap  [NUM_CKPT];
    ptr_t                  head;
    ptr_t                  tail;

    ptr_t                  n_req;
    ptr_t                  n_free;
    ptr_t                  head_alloc;
    ptr_t                  head_next;
    ptr_t                  tail_next;
    logic [COMMIT_WIDTH-1:0] free_vld;
    logic [PREG_WIDTH-1:0] free_idx [COMMIT_WIDTH];

    assign free_count = tail - head;

    always_comb begin
        n_req = '0;
        for (int k = 0; k < ALLOC_WIDTH; k++) begin
            n_req = n_req + ptr_t'(alloc_req[k]);
            alloc_preg[k*PREG_WIDTH +: PREG_WIDTH] = queue[PREG_WIDTH'(head + ptr_t'(k))];
        end
    end

    assign alloc_gnt  = (n_req != '0) && (free_count >= n_req) && !flush && !restore;
    assign head_alloc = alloc_gnt ? head + n_req : head;

    // P0 is never returned to the pool; valid lanes pack densely from the tail.
    always_comb begin
        n_free = '0;
        for (int k = 0; k < COMMIT_WIDTH; k++) begin
            free_vld[k] = commit_en[k] && (commit_old_preg[k*PREG_WIDTH +: PREG_WIDTH] != '0);
            free_idx[k] = PREG_WIDTH'(tail + n_free);
            if (free_vld[k]) begin
                n_free = n_free + ptr_t'(1);
            end
        end
    end

    assign tail_next = tail + n_free;

    always_comb begin
        if (flush) begin
            head_next = tail_next - FREE_N_P;
        end else if (restore) begin
            head_next = snap[restore_tag];
        end else begin
            head_next = head_alloc;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_PREGS; i++) begin
                queue[i] <= (i < FREE_N) ? PREG_WIDTH'(i + NUM_AREGS) : '0;
            end
            for (int i = 0; i < NUM_CKPT; i++) begin
                snap[i] <= '0;
            end
            head         <= '0;
            tail         <= FREE_N_P;
            overflow_err <= 1'b0;
        end else begin
            for (int k = 0; k < COMMIT_WIDTH; k++) begin
                if (free_vld[k]) begin
                    queue[free_idx[k]] <= commit_old_preg[k*PREG_WIDTH +: PREG_WIDTH];
                end
            end
            if (ckpt_save && !restore && !flush) begin
                snap[ckpt_tag] <= head_alloc;
            end
            head <= head_next;
            tail <= tail_next;
            if ((tail_next - head_next) > FREE_N_P) begin
                overflow_err <= 1'b1;
            end
        end
    end

endmodule
